// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// State encoding, register-zero constant and bubble-count range check.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int LU_MIN = 1;
  localparam int LU_MAX = 3;

  function automatic bit lu_ok(input int n);
    return (n >= LU_MIN) && (n <= LU_MAX);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Load-use bubbles, redirect squash, saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  generate
    if (!lu_ok(LU_BUBBLES)) begin : g_bad_lu
      $error("LU_BUBBLES out of range");
    end
  endgenerate

  localparam logic [1:0] BCNT_INIT = 2'(LU_BUBBLES - 1);

  hz_state_t  state;
  logic [1:0] bcnt;
  logic       hz;
  logic       src_hit;
  logic       stall_now;

  assign src_hit = (id_use_rs && (id_rs == ex_wreg))
                || (id_use_rt && (id_rt == ex_wreg));

  assign hz = id_valid && ex_valid && ex_memread
           && (ex_wreg != REG_ZERO) && src_hit;

  assign stall_now = !ex_redirect && ((state == BUBBLE) || hz);

  // Outputs are combinational so the stall lands in the hazard cycle.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_target = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_enable   = 1'b1;
    stalled       = 1'b0;
    if (reset) begin
      unique case (1'b1)
        ex_redirect: begin
          pc_sel_target = 1'b1;
          ifid_flush    = 1'b1;
          idex_enable   = 1'b0;
        end
        stall_now: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_enable = 1'b0;
          stalled     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      bcnt  <= 2'd0;
    end else if (ex_redirect) begin
      state <= RUN;
      bcnt  <= 2'd0;
    end else if (state == BUBBLE) begin
      bcnt <= bcnt - 2'd1;
      if (bcnt == 2'd1) state <= RUN;
    end else if (hz && (LU_BUBBLES > 1)) begin
      state <= BUBBLE;
      bcnt  <= BCNT_INIT;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stalled),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ex_redirect),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Four instances cover LU_BUBBLES=1/2/3 and a 4-bit counter build.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       ex_valid, ex_memread, ex_redirect;

  logic        pw[4], pst[4], iw[4], ifl[4], ie[4], st[4];
  logic [15:0] sc[3], fc[3];
  logic [3:0]  sc4, fc4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u1 (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .pc_write(pw[0]), .pc_sel_target(pst[0]),
    .ifid_write(iw[0]), .ifid_flush(ifl[0]), .idex_enable(ie[0]),
    .stalled(st[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipeline_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(16)) u2 (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .pc_write(pw[1]), .pc_sel_target(pst[1]),
    .ifid_write(iw[1]), .ifid_flush(ifl[1]), .idex_enable(ie[1]),
    .stalled(st[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  pipeline_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(16)) u3 (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .pc_write(pw[2]), .pc_sel_target(pst[2]),
    .ifid_write(iw[2]), .ifid_flush(ifl[2]), .idex_enable(ie[2]),
    .stalled(st[2]), .stall_cnt(sc[2]), .flush_cnt(fc[2]));

  pipeline_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4)) u4 (
    .clock(clk), .reset(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .pc_write(pw[3]), .pc_sel_target(pst[3]),
    .ifid_write(iw[3]), .ifid_flush(ifl[3]), .idex_enable(ie[3]),
    .stalled(st[3]), .stall_cnt(sc4), .flush_cnt(fc4));

  task automatic idle();
    id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_valid = 1'b0;
    ex_memread = 1'b0; ex_wreg = 5'd0; ex_redirect = 1'b0;
  endtask

  // ex: lw $w ; id: reads rs=$a (use_a) and rt=$b (use_b)
  task automatic drive(input logic [4:0] w, input logic [4:0] a,
                       input logic ua, input logic [4:0] b,
                       input logic ub, input logic rd);
    id_valid = 1'b1; id_rs = a; id_use_rs = ua;
    id_rt = b; id_use_rt = ub; ex_valid = 1'b1;
    ex_memread = 1'b1; ex_wreg = w; ex_redirect = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    total++;
    if ({pw[0], iw[0], ie[0], st[0], ifl[0], pst[0]} !== 6'b111000) begin
      bad++;
      $display("FAIL reset_outs got=%b want=111000",
               {pw[0], iw[0], ie[0], st[0], ifl[0], pst[0]});
    end
    total++;
    if (sc[0] !== 16'd0 || fc[0] !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnts got=%0d/%0d want=0/0", sc[0], fc[0]);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lu1();
    do_reset();
    drive(5'd5, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0);
    #1;
    total++;
    if ({pw[0], iw[0], ie[0], st[0]} !== 4'b0001) begin
      bad++;
      $display("FAIL lu1_stall got=%b want=0001",
               {pw[0], iw[0], ie[0], st[0]});
    end
    @(negedge clk);
    idle(); id_valid = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    total++;
    if ({pw[0], iw[0], ie[0], st[0]} !== 4'b1110) begin
      bad++;
      $display("FAIL lu1_resume got=%b want=1110",
               {pw[0], iw[0], ie[0], st[0]});
    end
    total++;
    if (sc[0] !== 16'd1) begin
      bad++;
      $display("FAIL lu1_cnt got=%0d want=1", sc[0]);
    end
  endtask

  task automatic test_lu2();
    do_reset();
    drive(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (st[1] !== 1'b1 || pw[1] !== 1'b0) begin
      bad++;
      $display("FAIL lu2_c1 got=%b%b want=10", st[1], pw[1]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({pw[1], iw[1], ie[1], st[1]} !== 4'b0001) begin
      bad++;
      $display("FAIL lu2_c2 got=%b want=0001",
               {pw[1], iw[1], ie[1], st[1]});
    end
    @(negedge clk); #1;
    total++;
    if (st[1] !== 1'b0 || ie[1] !== 1'b1) begin
      bad++;
      $display("FAIL lu2_c3 got=%b%b want=01", st[1], ie[1]);
    end
    total++;
    if (sc[1] !== 16'd2) begin
      bad++;
      $display("FAIL lu2_cnt got=%0d want=2", sc[1]);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    #1;
    total++;
    if (st[0] !== 1'b0 || pw[0] !== 1'b1) begin
      bad++;
      $display("FAIL reg0 got=%b%b want=01", st[0], pw[0]);
    end
    @(negedge clk);
    drive(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0);
    #1;
    total++;
    if (st[0] !== 1'b0 || ie[0] !== 1'b1) begin
      bad++;
      $display("FAIL unused_rt got=%b%b want=01", st[0], ie[0]);
    end
    @(negedge clk);
    drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    total++;
    if (st[0] !== 1'b1) begin
      bad++;
      $display("FAIL both_src got=%b want=1", st[0]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (sc[0] !== 16'd1) begin
      bad++;
      $display("FAIL both_cnt got=%0d want=1", sc[0]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    #1;
    total++;
    if ({pw[0], pst[0], iw[0], ifl[0], ie[0], st[0]} !== 6'b111100) begin
      bad++;
      $display("FAIL redir_outs got=%b want=111100",
               {pw[0], pst[0], iw[0], ifl[0], ie[0], st[0]});
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (fc[0] !== 16'd1 || sc[0] !== 16'd0) begin
      bad++;
      $display("FAIL redir_cnts got=%0d/%0d want=1/0", fc[0], sc[0]);
    end
    total++;
    if (ifl[0] !== 1'b0 || pst[0] !== 1'b0) begin
      bad++;
      $display("FAIL redir_after got=%b%b want=00", ifl[0], pst[0]);
    end
  endtask

  task automatic test_redirect_abort();
    do_reset();
    drive(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    idle(); ex_redirect = 1'b1;
    #1;
    total++;
    if (st[2] !== 1'b0 || ifl[2] !== 1'b1) begin
      bad++;
      $display("FAIL abort_redir got=%b%b want=01", st[2], ifl[2]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (st[2] !== 1'b0 || pw[2] !== 1'b1) begin
      bad++;
      $display("FAIL abort_run got=%b%b want=01", st[2], pw[2]);
    end
    total++;
    if (sc[2] !== 16'd1 || fc[2] !== 16'd1) begin
      bad++;
      $display("FAIL abort_cnts got=%0d/%0d want=1/1", sc[2], fc[2]);
    end
  endtask

  task automatic test_reset_mid_bubble();
    do_reset();
    drive(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    #1;
    total++;
    if (st[2] !== 1'b1) begin
      bad++;
      $display("FAIL mid_bubble got=%b want=1", st[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pw[2], iw[2], ie[2], st[2]} !== 4'b1110) begin
      bad++;
      $display("FAIL mid_rst_outs got=%b want=1110",
               {pw[2], iw[2], ie[2], st[2]});
    end
    total++;
    if (sc[2] !== 16'd0) begin
      bad++;
      $display("FAIL mid_rst_cnt got=%0d want=0", sc[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (st[2] !== 1'b0 || ie[2] !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_run got=%b%b want=01", st[2], ie[2]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) @(negedge clk);
    #1;
    total++;
    if (sc4 !== 4'd15) begin
      bad++;
      $display("FAIL sat_reach got=%0d want=15", sc4);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    total++;
    if (sc4 !== 4'd15 || st[3] !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold got=%0d/%b want=15/1", sc4, st[3]);
    end
    total++;
    if (sc[0] !== 16'd20) begin
      bad++;
      $display("FAIL sat_wide got=%0d want=20", sc[0]);
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_lu1();
    test_lu2();
    test_no_stall();
    test_redirect();
    test_redirect_abort();
    test_reset_mid_bubble();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; drives the write/enable controls of PC, IF/ID and ID/EX.
- Detects load-use hazards between the ID instruction and the load in EX and inserts a configurable number of bubbles. It does this by deasserting the ID/EX enable; an ID/EX register with enable low loads all-zero with valid low.
- Squashes wrong-path instructions on a taken branch or jump resolved in EX.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3, matching data-memory read latency.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_valid  in  1  EX stage valid, from ID/EX ovalid.
- ex_memread  in  1  EX instruction is a load.
- ex_wreg  in  5  EX destination register.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- pc_write  out  1  PC register load enable.
- pc_sel_target  out  1  PC selects the EX branch/jump target.
- ifid_write  out  1  IF/ID load enable; 0 holds.
- ifid_flush  out  1  IF/ID clears to NOP with valid low.
- idex_enable  out  1  ID/EX enable; 0 inserts a bubble.
- stalled  out  1  a load-use bubble is being inserted this cycle.
- stall_cnt  out  CNT_W  total bubble cycles inserted, saturating.
- flush_cnt  out  CNT_W  total redirect events, saturating.

Behaviour:
- Hazard condition (combinational) hz is true when all of the following hold:
  - id_valid and ex_valid and ex_memread are 1;
  - ex_wreg is not 0;
  - either (id_use_rs and id_rs equals ex_wreg) or (id_use_rt and id_rt equals ex_wreg).
- States: RUN and BUBBLE. A 2-bit counter bcnt holds the remaining bubble count.
- Outputs are combinational from state and inputs, so there are zero cycles of latency from hazard to stall. State and counters are registered.
- Priority is ex_redirect, then the bubble sequence, then hz, then normal flow.
- When ex_redirect=1 (any state):
  - Outputs: pc_write=1, pc_sel_target=1, ifid_flush=1, ifid_write=1, idex_enable=0, stalled=0.
  - Next state is RUN with bcnt=0.
  - flush_cnt increments by 1.
  - An in-progress bubble sequence is aborted.
- In RUN with hz=1:
  - Outputs: pc_write=0, ifid_write=0, idex_enable=0, stalled=1.
  - If LU_BUBBLES=1, stay in RUN. Otherwise go to BUBBLE with bcnt=LU_BUBBLES-1.
- In RUN with hz=0: pc_write=1, ifid_write=1, idex_enable=1, and every other output is 0.
- In BUBBLE:
  - Outputs: the same stall outputs as RUN with hz=1.
  - hz is not evaluated (EX already holds a bubble); the stall is forced by bcnt.
  - bcnt decrements each cycle. When bcnt reaches 1 and decrements, the next state is RUN.
- stall_cnt increments in every cycle where stalled=1. Both counters saturate at all-ones and never wrap.
- ifid_flush is 1 only on redirect. ifid_flush and ifid_write are never both active as a hold, because flush overrides write.
- Reset (reset=0, asynchronous, including mid-BUBBLE):
  - State becomes RUN, bcnt=0, stall_cnt=0, flush_cnt=0.
  - While reset is low, outputs are pc_write=1, ifid_write=1, idex_enable=1, and all other outputs 0.
- Simultaneous hz and ex_redirect: the redirect wins, no bubble is inserted and stall_cnt does not increment.
- A register-0 destination never stalls.
- A hazard on both rs and rt counts as a single hazard.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (RUN=1'b0, BUBBLE=1'b1);
  - the REG_ZERO constant;
  - the LU_BUBBLES legal range check.
- Natural sub-module: sat_counter (width CNT_W, inc, clear), instantiated twice, once for stall_cnt and once for flush_cnt.
- The hazard compare and the FSM stay in the top module.

Test Plan:
- Reset low mid-BUBBLE (LU_BUBBLES=3) -> state RUN immediately, counters 0, pc_write=1, idex_enable=1.
- LU_BUBBLES=1, ex: lw $5; id: add using rs=$5 -> one cycle with pc_write=0, ifid_write=0, idex_enable=0, then normal flow; stall_cnt=1.
- LU_BUBBLES=2, same hazard -> two consecutive stall cycles regardless of hz in cycle 2; stall_cnt=2.
- Load to $0 with id_rs=0, and a load to $7 with id_use_rt=0 while id_rt=7 -> no stall.
- hz=1 and ex_redirect=1 in the same cycle -> pc_sel_target=1, ifid_flush=1, idex_enable=0, stalled=0; flush_cnt=1, stall_cnt unchanged.
- CNT_W=4: 20 consecutive hazards -> stall_cnt holds at 15 and does not wrap.
